// File: rtl/vector_recorder.sv
// Capture buffer: records WIDTH-bit test vectors into a small memory during CAPTURE,
// then returns them one per rd_req during DUMP.
module vector_recorder #(
    parameter  int WIDTH  = 4,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              sample_valid,
    input  logic [WIDTH-1:0]  sample,
    input  logic              rd_req,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DUMP    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE       = (ADDR_W + 1)'(1);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W:0]    rd_ptr;
    logic               wr_en;
    logic               rd_en;
    logic               rd_end;

    assign full = (count == DEPTH_CNT);
    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start overrides everything; a full buffer serves reads during its last CAPTURE cycle
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_next = state;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        rd_end     = 1'b0;
        if (start) begin
            state_next = CAPTURE;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                CAPTURE: begin
                    wr_en = sample_valid && !full;
                    rd_en = full && rd_req;
                    if (stop || full) begin
                        state_next = DUMP;
                    end
                end
                DUMP: begin
                    if (rd_req) begin
                        if (rd_ptr < count) begin
                            rd_en = 1'b1;
                        end else begin
                            rd_end     = 1'b1;
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            done     <= rd_end;
            if (start) begin
                count  <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    count <= count + ONE;
                end
                if (rd_en) begin
                    rd_data <= mem[rd_ptr[ADDR_W-1:0]];
                    rd_ptr  <= rd_ptr + ONE;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags are cleared, and a reset edge never writes.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[count[ADDR_W-1:0]] <= sample;
        end
    end

endmodule

// File: tb/tb_vector_recorder.sv
// Self-checking bench for vector_recorder: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_vector_recorder;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic              sample_valid;
    logic [WIDTH-1:0]  sample;
    logic              rd_req;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_fail   = 0;

    vector_recorder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .sample       (sample),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference model: recorded words live in a queue, readout walks an index through it.
    typedef enum {M_IDLE, M_CAPTURE, M_DUMP} mode_t;
    mode_t             m_mode;
    logic [WIDTH-1:0]  m_words [$];
    int                m_rd_idx;
    logic [WIDTH-1:0]  m_data;
    bit                m_valid;
    bit                m_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit was_full;
        m_valid = 1'b0;
        m_done  = 1'b0;
        if (reset) begin
            m_mode   = M_IDLE;
            m_words.delete();
            m_rd_idx = 0;
            m_data   = '0;
        end else if (start) begin
            m_mode   = M_CAPTURE;
            m_words.delete();
            m_rd_idx = 0;
        end else if (m_mode == M_CAPTURE) begin
            was_full = (m_words.size() == DEPTH);
            if (was_full && rd_req) begin
                m_data  = m_words[m_rd_idx];
                m_rd_idx++;
                m_valid = 1'b1;
            end
            if (sample_valid && !was_full) m_words.push_back(sample);
            if (stop || was_full) m_mode = M_DUMP;
        end else if (m_mode == M_DUMP && rd_req) begin
            if (m_rd_idx < m_words.size()) begin
                m_data  = m_words[m_rd_idx];
                m_rd_idx++;
                m_valid = 1'b1;
            end else begin
                m_done = 1'b1;
                m_mode = M_IDLE;
            end
        end
    endtask

    task automatic compare_all();
        check("count",    32'(count),    32'(m_words.size()));
        check("full",     32'(full),     32'(m_words.size() == DEPTH));
        check("busy",     32'(busy),     32'(m_mode != M_IDLE));
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("done",     32'(done),     32'(m_done));
        check("rd_data",  32'(rd_data),  32'(m_data));
    endtask

    // Drive inputs away from the edge, advance one clock, update the model, then compare.
    task automatic cyc(input bit st, input bit sp, input bit sv,
                       input logic [WIDTH-1:0] s, input bit rr);
        start        = st;
        stop         = sp;
        sample_valid = sv;
        sample       = s;
        rd_req       = rr;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic read_cyc();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    logic [WIDTH-1:0] basic_words [3];

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0; sample = '0; rd_req = 1'b0;
        m_mode = M_IDLE; m_rd_idx = 0; m_data = '0; m_valid = 1'b0; m_done = 1'b0;
        basic_words[0] = 4'b0001;
        basic_words[1] = 4'b0100;
        basic_words[2] = 4'b1011;

        idle_cyc();
        idle_cyc();
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_busy",    32'(busy),    32'd0);
        reset = 1'b0;
        idle_cyc();

        // Basic record/playback
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, basic_words[i], 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("basic_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            read_cyc();
            check("basic_rd_valid", 32'(rd_valid), 32'd1);
            check("basic_rd_data",  32'(rd_data),  32'(basic_words[i]));
        end
        read_cyc();
        check("basic_done",    32'(done),     32'd1);
        check("basic_novalid", 32'(rd_valid), 32'd0);
        check("basic_busy",    32'(busy),     32'd0);
        idle_cyc();

        // Fill to DEPTH, 17th sample dropped, auto-DUMP
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
        check("fill_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            read_cyc();
            check("fill_rd_data", 32'(rd_data), 32'(i));
        end
        read_cyc();
        check("fill_done", 32'(done), 32'd1);
        check("fill_full_kept", 32'(full), 32'd1);

        // stop together with sample_valid
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0011, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'b0101, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 4'b1110, 1'b0);
        check("stopsv_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) read_cyc();
        check("stopsv_last", 32'(rd_data), 32'(4'b1110));
        read_cyc();

        // Empty capture
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        read_cyc();
        check("empty_novalid", 32'(rd_valid), 32'd0);
        check("empty_done",    32'(done),     32'd1);
        check("empty_count",   32'(count),    32'd0);

        // Abort during DUMP, then reset mid-capture
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, WIDTH'(i + 7), 1'b0);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        read_cyc();
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        check("abort_count",   32'(count),    32'd0);
        check("abort_busy",    32'(busy),     32'd1);
        check("abort_done",    32'(done),     32'd0);
        check("abort_novalid", 32'(rd_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 4'hA, 1'b0);
        reset = 1'b0;
        check("rst_count",   32'(count),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 4'h5, 1'b1);
        check("idle_ignore_count", 32'(count), 32'd0);

        // Ignored inputs
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'hC, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
        read_cyc();
        check("cap_rdreq_valid", 32'(rd_valid), 32'd0);
        check("cap_rdreq_count", 32'(count),    32'd2);
        cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 4'h6, 1'b0);
        check("dump_sv_count", 32'(count),    32'd2);
        check("dump_sv_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 3; i++) read_cyc();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(199) == 0);
            cyc($urandom_range(99) < 3, $urandom_range(99) < 6, $urandom_range(99) < 55,
                WIDTH'($urandom), $urandom_range(99) < 40);
        end
        reset = 1'b0;
        idle_cyc();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/vector_recorder.md
# vector_recorder

Synthesizable capture buffer that records packed test vectors `{a, b, c, y}` from a live design into an on-chip memory, then plays them back word by word. It is the writer for the test-vector files our benches load with `$readmemb`. Each recorded word has the same 4-bit format the benches consume, so a dump can be written out line by line as a golden vector file. It sits beside the device under observation and is controlled by a simple start/stop/read handshake.

## Interface

Parameters:
- `WIDTH`, 4: bits per vector word; `{inputs, output}` packed MSB-first.
- `DEPTH`, 16: number of words in the capture memory; must be ≥2.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width, derived, not overridden.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: arm capture; clears count.
- `stop` in 1: end capture and enter readout.
- `sample_valid` in 1: `sample` is recorded this cycle.
- `sample` in WIDTH: vector word to record.
- `rd_req` in 1: request next stored word during readout.
- `rd_data` out WIDTH: read word; valid when `rd_valid`=1.
- `rd_valid` out 1: one-cycle pulse per returned word.
- `count` out ADDR_W+1: number of words captured.
- `full` out 1: `count == DEPTH`.
- `busy` out 1: high in CAPTURE or DUMP.
- `done` out 1: one-cycle pulse when readout completes.

## Operation

- States: IDLE, CAPTURE, DUMP.
- **IDLE:**
  - `start` → CAPTURE; `count`←0, `wr_ptr`←0.
  - `stop`, `sample_valid` and `rd_req` are ignored.
- **CAPTURE:**
  - `sample_valid`=1 and not full: `mem[wr_ptr]`←`sample`, `wr_ptr`++, `count`++.
  - Write that makes `count`=DEPTH: `full`=1 and auto-transition to DUMP next cycle.
  - `stop` → DUMP with `rd_ptr`←0.
  - `stop` together with `sample_valid`: the sample is written first, then DUMP.
- **DUMP:**
  - `rd_req`=1 and `rd_ptr` < `count`: `rd_data`←`mem[rd_ptr]`, `rd_valid`=1 next cycle, `rd_ptr`++.
  - `rd_req` when `rd_ptr` = `count` (including `count`=0): no `rd_valid`; `done` pulses next cycle; → IDLE.
  - `sample_valid` is ignored.
- **`start` in CAPTURE or DUMP:** aborts the current operation and restarts CAPTURE with `count`←0. Any pending `rd_valid`/`done` for that cycle is suppressed.
- **`start` and `stop` in the same cycle:** `start` wins.
- **Memory:** contents are not reset; only pointers and flags are. `count` holds its value through DUMP and after returning to IDLE, until the next `start`.
- **`full`:** derived from `count`. It stays high through DUMP and IDLE until the next `start`.
- **Reset mid-operation:** returns to IDLE next edge. All outputs take their reset values and the memory is untouched.

## Timing

- Reset values: state IDLE, `count`=0, `full`=0, `busy`=0, `rd_valid`=0, `done`=0, `rd_data`=0.
- Capture latency: a word presented with `sample_valid` at edge N is stored at edge N; `count` reflects it after edge N.
- Read latency: `rd_req` sampled at edge N produces `rd_data`/`rd_valid` after edge N, i.e. 1 cycle. Back-to-back `rd_req` yields one word per cycle.
- `busy` rises the cycle after `start` is sampled and falls the cycle `done` pulses.
- Full auto-transition: the write at edge N sets `full`. The state is DUMP after edge N+1, and `rd_req` is honoured from edge N+1.
- `rd_data` holds its last value when `rd_valid`=0.

## Test plan

- **Basic record/playback:** `start`, then samples 4'b0001, 4'b0100, 4'b1011 on 3 consecutive cycles, then `stop`. Expect `count`=3. Three `rd_req` return 0001, 0100, 1011 with `rd_valid` 1 cycle after each request. A 4th `rd_req` gives a `done` pulse, no `rd_valid`, and `busy`=0.
- **Fill to DEPTH=16:** `start`, then 16 valid samples 0..15 and a 17th sample 4'hF. Expect `full`=1 and `count`=16, the 17th sample not stored, and auto-DUMP. Readout returns 0..15 in order.
- **Simultaneous `stop` + `sample_valid`** with 4'b1110 after 2 prior samples: `count`=3 and the last read word is 1110.
- **Empty capture:** `start` then immediate `stop`, then `rd_req`. Expect no `rd_valid`, a `done` pulse 1 cycle later, and `count`=0.
- **Abort and reset:** `start` during DUMP after 1 of 3 reads completes. Expect `count`=0, CAPTURE, no `done`. Then assert `reset` mid-capture: all outputs at reset values next cycle, and `sample_valid` is ignored in IDLE.
- **Ignored inputs:** `rd_req` during CAPTURE and `sample_valid` during DUMP change nothing. `rd_valid` stays 0 and `count` is unchanged.
